// File: rtl/sweep_counter_if.sv
// Control/status bundle for sweep_counter: enable, mode, step, modulus, load and registered outputs.
interface sweep_counter_if #(
  parameter int WIDTH = 8
);
  logic             i_en;
  logic             i_mode;
  logic [WIDTH-1:0] i_step;
  logic [WIDTH-1:0] i_max;
  logic             i_load;
  logic [WIDTH-1:0] i_load_val;
  logic [WIDTH-1:0] o_data;
  logic             o_dir;
  logic             o_tc;

  modport master (
    output i_en, i_mode, i_step, i_max, i_load, i_load_val,
    input  o_data, o_dir, o_tc
  );

  modport slave (
    input  i_en, i_mode, i_step, i_max, i_load, i_load_val,
    output o_data, o_dir, o_tc
  );
endinterface

// File: rtl/sweep_counter.sv
// Programmable sawtooth/triangle counter, outputs registered on the enabling edge, no backpressure.
// Define SWEEP_COUNTER_LOAD_EN to enable the synchronous load port; otherwise load is ignored.
module sweep_counter #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  sweep_counter_if.slave s
);

  logic [WIDTH-1:0] r_data;
  logic             r_dir;
  logic             r_tc;

  logic [WIDTH-1:0] w_data_nxt;
  logic             w_dir_nxt;
  logic             w_tc_nxt;
  logic [WIDTH-1:0] w_step_eff;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrap;
  logic             w_load;

`ifdef SWEEP_COUNTER_LOAD_EN
  assign w_load = s.i_load;
`else
  assign w_load = 1'b0;
  wire w_unused_load = &{1'b0, s.i_load, s.i_load_val};
`endif

  assign w_step_eff = (s.i_step > s.i_max) ? s.i_max : s.i_step;
  // Sum carried at WIDTH+1 bits so max=all-ones never overflows.
  assign w_sum      = {1'b0, r_data} + {1'b0, w_step_eff};
  assign w_wrap     = w_sum - ({1'b0, s.i_max} + {{WIDTH{1'b0}}, 1'b1});

  always_comb begin
    w_data_nxt = r_data;
    w_dir_nxt  = r_dir;
    w_tc_nxt   = 1'b0;
    if (w_load) begin
      w_data_nxt = s.i_load_val;
      w_dir_nxt  = 1'b1;
    end else if (s.i_en) begin
      if (r_data > s.i_max) begin
        // Modulus lowered under the count: snap to the natural turnaround point.
        w_tc_nxt = 1'b1;
        if (s.i_mode) begin
          w_data_nxt = s.i_max;
          w_dir_nxt  = 1'b0;
        end else begin
          w_data_nxt = '0;
          w_dir_nxt  = 1'b1;
        end
      end else if (w_step_eff != '0) begin
        if (!s.i_mode) begin
          w_dir_nxt = 1'b1;
          if (w_sum > {1'b0, s.i_max}) begin
            w_data_nxt = w_wrap[WIDTH-1:0];
            w_tc_nxt   = 1'b1;
          end else begin
            w_data_nxt = w_sum[WIDTH-1:0];
          end
        end else if (r_dir) begin
          if (w_sum >= {1'b0, s.i_max}) begin
            w_data_nxt = s.i_max;
            w_dir_nxt  = 1'b0;
            w_tc_nxt   = 1'b1;
          end else begin
            w_data_nxt = w_sum[WIDTH-1:0];
          end
        end else begin
          if (r_data <= w_step_eff) begin
            w_data_nxt = '0;
            w_dir_nxt  = 1'b1;
            w_tc_nxt   = 1'b1;
          end else begin
            w_data_nxt = r_data - w_step_eff;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
      r_dir  <= 1'b1;
      r_tc   <= 1'b0;
    end else begin
      r_data <= w_data_nxt;
      r_dir  <= w_dir_nxt;
      r_tc   <= w_tc_nxt;
    end
  end

  assign s.o_data = r_data;
  assign s.o_dir  = r_dir;
  assign s.o_tc   = r_tc;

endmodule

// File: doc/sweep_counter.md
# sweep_counter

Parametrised programmable counter used to address waveform tables and step DAC codes. Generalises a fixed-modulus 8-bit wrap counter into a WIDTH-bit counter with run-time modulus, run-time step size, and two modes: sawtooth (wrap) and triangle (bounce). A registered terminal-count pulse marks each wrap or turnaround and lets downstream blocks chain or count periods.

## Interface
- WIDTH, 8: counter, step and modulus width in bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; one step per clk edge while high.
- mode  in  1  0 = wrap (sawtooth), 1 = bounce (triangle).
- step  in  WIDTH  increment per enabled cycle.
- max  in  WIDTH  upper bound; the count range is 0..max inclusive.
- load  in  1  synchronous load strobe (active only with SWEEP_COUNTER_LOAD_EN).
- load_val  in  WIDTH  value written on load.
- data  out  WIDTH  registered count.
- dir  out  1  registered direction, 1 = up, 0 = down.
- tc  out  1  registered terminal-count pulse, one cycle wide.

## Operation
- Reset values: data = 0, dir = 1, tc = 0. Reset applies immediately, with no clock edge required.
- Priority on each clk edge: load (if compiled in) > en > hold.
- step_eff = min(step, max). If step_eff = 0, data and dir hold and tc = 0.
- sum = data + step_eff, computed at WIDTH+1 bits so it never overflows.
- Wrap mode (dir forced to 1):
  - sum <= max: data <= sum, tc <= 0.
  - sum > max: data <= sum - (max+1), tc <= 1 (modulo max+1).
- Bounce mode, dir = 1:
  - sum >= max: data <= max, dir <= 0, tc <= 1.
  - Otherwise: data <= sum.
- Bounce mode, dir = 0:
  - data <= step_eff: data <= 0, dir <= 1, tc <= 1.
  - Otherwise: data <= data - step_eff.
- Both endpoints 0 and max are always visited in bounce mode (saturating turnaround).
- Out of range (data > max, e.g. max lowered at run time), on the next enabled cycle:
  - Wrap mode: data <= 0, tc <= 1.
  - Bounce mode: data <= max, dir <= 0, tc <= 1.
- Mode change takes effect on the next enabled edge. Switching to wrap sets dir <= 1 on that edge.
- en = 0: data and dir hold, tc <= 0.
- max, step and mode are sampled every edge and need no quiescing.

## Timing
- Latency: data, dir and tc update on the same clk edge where en (or load) is sampled high. All outputs are registered; no combinational input-to-output path exists.
- tc is high for exactly the one cycle in which data holds the post-wrap or turnaround value.
- Consecutive enabled cycles may produce back-to-back tc pulses, for example step_eff = max in wrap mode.
- Load: data <= load_val, dir <= 1, tc <= 0 on the sampling edge, regardless of en. An out-of-range load_val is corrected by the out-of-range rule on the next enabled edge.
- Asserting rst mid-count clears all outputs asynchronously. Counting resumes from 0 on the first enabled edge after release.

## Configuration
- SWEEP_COUNTER_LOAD_EN defined: load/load_val behave as specified above.
- Not defined: the load and load_val ports remain present but are ignored, and no load logic is synthesised.

## Test plan
- WIDTH=8, wrap, max=9, step=3, en=1 -> data 0,3,6,9,2,5,8,1; tc high only with the first 2 and with 1.
- Bounce, max=10, step=4 -> data 0,4,8,10,6,2,0,4; dir falls with 10 and rises with 0; tc high exactly on those two cycles.
- Wrap, max=255, step=1 from data=254 -> 255 then 0 with tc=1, no overflow; with en=0 for 3 cycles, data holds and tc=0.
- max=4, step=7 -> step_eff=4: 0,4,3(tc),2(tc),1(tc). With step=0 -> data frozen, tc=0.
- data=8 in wrap mode, max changed to 5 -> next enabled edge gives data 0, tc=1; repeat in bounce mode -> data 5, dir 0, tc=1.
- With SWEEP_COUNTER_LOAD_EN, load=1, load_val=200, en=0 -> data 200 next edge, dir 1. Without the macro -> data unchanged. rst pulse mid-count between edges -> data 0, dir 1, tc 0 immediately.
